// File: rtl/muxn_pkg.sv
// Shared types, defaults and the next-channel search for the registered scan mux.
package muxn_pkg;

   localparam int DEF_N     = 4;
   localparam int DEF_W     = 1;
   localparam int DEF_DWELL = 1;
   localparam int MAX_N     = 64;
   localparam int IDX_W     = 8;

   typedef enum logic {
      MUX_MANUAL,
      MUX_SCAN
   } mode_e;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             wrap;
      logic             found;
   } next_t;

   // Ascending search for the next enabled channel after current, wrapping at n.
   // An out-of-range current restarts the search from channel 0.
   function automatic next_t next_chan(input int current, input logic [MAX_N-1:0] mask,
                                       input int n);
      next_t r;
      int    base;
      int    cand;
      r.idx   = IDX_W'(current);
      r.wrap  = 1'b0;
      r.found = 1'b0;
      base    = (current >= n) ? n - 1 : current;
      for (int k = 1; k <= MAX_N; k++) begin
         cand = base + k;
         if (cand >= n) cand = cand - n;
         if (k <= n && !r.found && mask[cand]) begin
            r.idx   = IDX_W'(cand);
            r.wrap  = (cand <= current);
            r.found = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/muxn_comb.sv
// Purely combinational N-to-1, W-bit multiplexer; out-of-range selects give zero.
module muxn_comb #(
   parameter  int N    = 4,
   parameter  int W    = 1,
   localparam int SELW = $clog2(N)
) (
   input  logic [N*W-1:0]  din,
   input  logic [SELW-1:0] sel,
   output logic [W-1:0]    out
);

   always_comb begin
      // NOTE: out gets a default before the loop so no select value infers a latch.
      out = '0;
      for (int k = 0; k < N; k++) begin
         if (sel == SELW'(k)) out = din[k*W +: W];
      end
   end

endmodule

// File: rtl/muxn_scan_reg.sv
// Registered N-input scan multiplexer with manual select and timed auto-scan.
// Optional per-channel enable mask when MUXN_CHMASK_EN is defined.
module muxn_scan_reg
   import muxn_pkg::*;
#(
   parameter  int N     = DEF_N,
   parameter  int W     = DEF_W,
   parameter  int DWELL = DEF_DWELL,
   localparam int SELW  = $clog2(N)
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic [N*W-1:0]  din,
   input  logic [SELW-1:0] sel,
   input  logic            scan,
`ifdef MUXN_CHMASK_EN
   input  logic [N-1:0]    chmask,
`endif
   output logic [W-1:0]    y,
   output logic [SELW-1:0] ch,
   output logic            valid,
   output logic            wrap
);

   localparam int                CNTW     = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int                NSEL     = 2 ** SELW;
   localparam logic [CNTW-1:0]   CNT_LAST = CNTW'(DWELL - 1);

   logic [SELW-1:0]  r_ch;
   logic [CNTW-1:0]  r_cnt;
   logic [W-1:0]     r_y;
   logic             r_valid;
   logic             r_wrap;

   logic [N-1:0]     w_mask;
   logic [NSEL-1:0]  w_mask_sel;
   logic [MAX_N-1:0] w_mask_pkg;
   mode_e            w_mode;
   next_t            w_next;
   logic [SELW-1:0]  w_tgt;
   logic             w_tgt_ok;
   logic             w_adv_wrap;
   logic [CNTW-1:0]  w_cnt_nxt;
   logic [W-1:0]     w_mux;
   logic             w_unused;

`ifdef MUXN_CHMASK_EN
   assign w_mask = chmask;
`else
   assign w_mask = '1;
`endif

   // Zero-extended masks: indexing by any select value lands on a defined bit.
   always_comb begin
      w_mask_sel         = '0;
      w_mask_sel[N-1:0]  = w_mask;
      w_mask_pkg         = '0;
      w_mask_pkg[N-1:0]  = w_mask;
   end

   assign w_mode   = scan ? MUX_SCAN : MUX_MANUAL;
   assign w_next   = next_chan(int'(r_ch), w_mask_pkg, N);
   assign w_unused = ^w_next.idx[IDX_W-1:SELW];

   always_comb begin
      w_tgt      = r_ch;
      w_tgt_ok   = 1'b0;
      w_adv_wrap = 1'b0;
      w_cnt_nxt  = '0;
      case (w_mode)
         MUX_MANUAL: begin
            w_tgt    = sel;
            w_tgt_ok = w_mask_sel[sel];
         end
         MUX_SCAN: begin
            if (!w_next.found) begin
               w_tgt = r_ch;
            end else if (!w_mask_sel[r_ch] || r_cnt == CNT_LAST) begin
               w_tgt      = w_next.idx[SELW-1:0];
               w_tgt_ok   = 1'b1;
               w_adv_wrap = w_next.wrap;
            end else begin
               w_tgt_ok  = 1'b1;
               w_cnt_nxt = r_cnt + CNTW'(1);
            end
         end
         default: ;
      endcase
   end

   // The mux sees the channel that will be registered, keeping y and ch consistent.
   muxn_comb #(
      .N (N),
      .W (W)
   ) u_mux (
      .din (din),
      .sel (w_tgt),
      .out (w_mux)
   );

   always_ff @(posedge CLK) begin
      // NOTE: state updates are nonblocking so every register samples pre-edge values.
      if (RESET) begin
         r_ch    <= '0;
         r_cnt   <= '0;
         r_y     <= '0;
         r_valid <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_ch    <= w_tgt;
         r_cnt   <= w_cnt_nxt;
         r_y     <= w_tgt_ok ? w_mux : '0;
         r_valid <= w_tgt_ok;
         r_wrap  <= w_adv_wrap;
      end
   end

   assign y     = r_y;
   assign ch    = r_ch;
   assign valid = r_valid;
   assign wrap  = r_wrap;

endmodule
